// File: rtl/eq_pkg.sv
// Shared types and the band-code to stage-code mapping for the EQ band sequencer.
package eq_pkg;

    // Sequencer states; exposed on state_dbg so checkers can follow the FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        SET   = 2'd3
    } state_t;

    // Default maximum code a single filter stage accepts.
    localparam int STAGE_MAX_DEF = 4;

    // Split an already-clamped band code into four stage codes.
    // Boost fills the second positive stage (g2) first, then the first (g0);
    // cut fills the second negative stage (g3) first, then the first (g1).
    function automatic void map_band(input int code, input int stage_max,
                                     output int g0, output int g1,
                                     output int g2, output int g3);
        int d;
        d  = code - 2 * stage_max;
        g0 = 0;
        g1 = 0;
        g2 = 0;
        g3 = 0;
        if (d >= 0) begin
            g2 = (d > stage_max) ? stage_max : d;
            g0 = d - g2;
        end else begin
            g3 = (-d > stage_max) ? stage_max : -d;
            g1 = -d - g3;
        end
    endfunction

endpackage

// File: rtl/eq_band_sequencer_if.sv
// Filter-chain bus between the sequencer (master) and the Po/Ne/Po/Ne chain (slave).
//
// Handshake: f_in_valid and f_out_valid are single-cycle strobes with no
// back-pressure; a sample moves on every cycle its strobe is high. Upstream
// samples are offered with din_valid and are only taken while in_ready is high;
// anything offered while in_ready is low is dropped.
interface eq_band_sequencer_if #(
    parameter int DIN_W  = 16,
    parameter int DOUT_W = 19,
    parameter int SG_W   = 3
);
    logic              f_in_valid;
    logic [DIN_W-1:0]  f_din;
    logic              f_gainwe;
    logic              f_gainset;
    logic [4*SG_W-1:0] f_gain;
    logic              f_out_valid;
    logic [DOUT_W-1:0] f_dout;

    modport master (
        output f_in_valid, f_din, f_gainwe, f_gainset, f_gain,
        input  f_out_valid, f_dout
    );

    modport slave (
        input  f_in_valid, f_din, f_gainwe, f_gainset, f_gain,
        output f_out_valid, f_dout
    );
endinterface

// File: rtl/eq_gain_map.sv
// Combinational clamp of one band code plus its split into {g0,g1,g2,g3}.
module eq_gain_map
    import eq_pkg::*;
#(
    parameter int GAIN_W    = 8,
    parameter int STAGE_MAX = STAGE_MAX_DEF,
    parameter int SG_W      = $clog2(STAGE_MAX + 1)
) (
    input  logic [GAIN_W-1:0] code,
    output logic [4*SG_W-1:0] stages,
    output logic              clamp
);
    localparam int CODE_MAX = 4 * STAGE_MAX;

    // Clamp out-of-range codes to full boost, then split into stage codes.
    always_comb begin : map_blk
        int code_i;
        int g0;
        int g1;
        int g2;
        int g3;
        code_i = 32'(code);
        clamp  = (code_i > CODE_MAX);
        if (clamp) begin
            code_i = CODE_MAX;
        end
        map_band(code_i, STAGE_MAX, g0, g1, g2, g3);
        stages = {SG_W'(g0), SG_W'(g1), SG_W'(g2), SG_W'(g3)};
    end
endmodule

// File: rtl/eq_band_sequencer.sv
// Gain sequencer for the multi-band EQ cascade: drains the chain, loads every
// band through gainwe, commits with gainset, and switches EQ/bypass only when
// the chain is empty so no sample is ever split between paths.
module eq_band_sequencer
    import eq_pkg::*;
#(
    parameter int N_BANDS      = 10,
    parameter int GAIN_W       = 8,
    parameter int STAGE_MAX    = STAGE_MAX_DEF,
    parameter int SG_W         = $clog2(STAGE_MAX + 1),
    parameter int DIN_W        = 16,
    parameter int DOUT_W       = 19,
    parameter int MAX_INFLIGHT = 63
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_BANDS*GAIN_W-1:0] gain_all,
    input  logic                      gain_change,
    input  logic                      eq_switch,
    input  logic                      din_valid,
    input  logic [DIN_W-1:0]          din,
    output logic                      in_ready,
    eq_band_sequencer_if.master       fch,
    output logic                      out_valid,
    output logic [DOUT_W-1:0]         dout,
    output logic                      busy,
    output logic                      err_clamp,
    output logic                      err_flow,
    output state_t                    state_dbg
);
    localparam int IDX_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    state_t                    state;
    logic                      pending;
    logic [IDX_W-1:0]          idx;
    logic [N_BANDS*GAIN_W-1:0] snap;
    logic                      gainwe_q;
    logic                      gainset_q;
    logic [CNT_W-1:0]          inflight;
    logic                      eq_active;
    logic                      fin_valid;
    logic [GAIN_W-1:0]         band_code;
    logic [4*SG_W-1:0]         band_stages;
    logic                      band_clamp;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign fin_valid = din_valid & in_ready & eq_active;

    assign band_code = snap[32'(idx) * GAIN_W +: GAIN_W];

    eq_gain_map #(
        .GAIN_W   (GAIN_W),
        .STAGE_MAX(STAGE_MAX),
        .SG_W     (SG_W)
    ) u_map (
        .code  (band_code),
        .stages(band_stages),
        .clamp (band_clamp)
    );

    assign fch.f_in_valid = fin_valid;
    assign fch.f_din      = din;
    assign fch.f_gainwe   = gainwe_q;
    assign fch.f_gainset  = gainset_q;
    assign fch.f_gain     = (state == LOAD) ? band_stages : '0;

    // Reprogramming FSM: request capture, drain, per-band load, commit pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pending   <= 1'b0;
            idx       <= '0;
            snap      <= '0;
            gainwe_q  <= 1'b0;
            gainset_q <= 1'b0;
            err_clamp <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gain_change || pending) begin
                        state   <= DRAIN;
                        pending <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (gain_change) pending <= 1'b1;
                    if (inflight == '0) begin
                        state     <= LOAD;
                        snap      <= gain_all;
                        idx       <= '0;
                        err_clamp <= 1'b0;
                        gainwe_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (gain_change) pending <= 1'b1;
                    if (band_clamp) err_clamp <= 1'b1;
                    if (idx == IDX_W'(N_BANDS - 1)) begin
                        state     <= SET;
                        gainwe_q  <= 1'b0;
                        gainset_q <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                SET: begin
                    if (gain_change) pending <= 1'b1;
                    gainset_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Samples inside the filter chain; an output with nothing in flight is an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
            err_flow <= 1'b0;
        end else if (fin_valid && !fch.f_out_valid) begin
            if (inflight != CNT_W'(MAX_INFLIGHT)) inflight <= inflight + CNT_W'(1);
        end else if (!fin_valid && fch.f_out_valid) begin
            if (inflight == '0) err_flow <= 1'b1;
            else                inflight <= inflight - CNT_W'(1);
        end
    end

    // Mode changes only take effect with the sequencer idle and the chain empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eq_active <= 1'b0;
        end else if (state == IDLE && inflight == '0) begin
            eq_active <= eq_switch;
        end
    end

    // Output register: filter result in EQ mode, sign-extended input in bypass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (eq_active) begin
            out_valid <= fch.f_out_valid;
            dout      <= fch.f_dout;
        end else begin
            out_valid <= din_valid & in_ready;
            dout      <= {{(DOUT_W - DIN_W){din[DIN_W-1]}}, din};
        end
    end
endmodule

// File: tb/tb_eq_band_sequencer.sv
// Self-checking bench for eq_band_sequencer at default parameters.
module tb_eq_band_sequencer;
  import eq_pkg::*;

  localparam int N      = 10;
  localparam int GW     = 8;
  localparam int DIN_W  = 16;
  localparam int DOUT_W = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N*GW-1:0]   gain_all = '0;
  logic              gain_change = 1'b0;
  logic              eq_switch = 1'b0;
  logic              din_valid = 1'b0;
  logic [DIN_W-1:0]  din = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DOUT_W-1:0] dout;
  logic              busy;
  logic              err_clamp;
  logic              err_flow;
  state_t            state_dbg;

  eq_band_sequencer_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .SG_W(3)) fch ();

  eq_band_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .gain_all   (gain_all),
    .gain_change(gain_change),
    .eq_switch  (eq_switch),
    .din_valid  (din_valid),
    .din        (din),
    .in_ready   (in_ready),
    .fch        (fch),
    .out_valid  (out_valid),
    .dout       (dout),
    .busy       (busy),
    .err_clamp  (err_clamp),
    .err_flow   (err_flow),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [DOUT_W-1:0] exp_q[$];
  int band_q[N];

  // Reference: level above 0 dB goes to the positive stages, below to the
  // negative stages; the later stage of each pair absorbs the first 4 steps.
  function automatic logic [11:0] ref_gain(input int code);
    int lvl, boost, cut;
    lvl   = ((code > 16) ? 16 : code) - 8;
    boost = (lvl > 0) ? lvl : 0;
    cut   = (lvl < 0) ? -lvl : 0;
    return {3'((boost > 4) ? boost - 4 : 0), 3'((cut > 4) ? cut - 4 : 0),
            3'((boost > 4) ? 4 : boost),     3'((cut > 4) ? 4 : cut)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pack_bands();
    for (int i = 0; i < N; i++) gain_all[i*GW +: GW] = GW'(band_q[i]);
  endtask

  task automatic rand_legal();
    for (int i = 0; i < N; i++) band_q[i] = $urandom_range(0, 16);
  endtask

  // Pulse gain_change from IDLE; lands at the DRAIN cycle.
  task automatic issue_change();
    pack_bands();
    gain_change = 1'b1;
    @(negedge clk);
    gain_change = 1'b0;
    n_cmp++;
    if (state_dbg !== DRAIN || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_entry: state=%0d busy=%b in_ready=%b want state=1 busy=1 in_ready=0",
               state_dbg, busy, in_ready);
    end
  endtask

  // From a DRAIN cycle with nothing in flight: check all LOAD cycles, SET, IDLE.
  // gain_change is held for LOAD cycles inject and inject+1 when inject >= 0.
  task automatic check_load(input int inject);
    logic clamped;
    logic [11:0] g;
    clamped = 1'b0;
    for (int i = 0; i < N; i++) begin
      gain_change = (inject >= 0) && (i == inject || i == inject + 1);
      @(negedge clk);
      g = ref_gain(band_q[i]);
      n_cmp++;
      if (fch.f_gainwe !== 1'b1 || fch.f_gainset !== 1'b0 || fch.f_gain !== g ||
          err_clamp !== clamped || state_dbg !== LOAD) begin
        n_fail++;
        $display("FAIL load_band%0d: we=%b set=%b gain=%h clamp=%b state=%0d want we=1 set=0 gain=%h clamp=%b state=2",
                 i, fch.f_gainwe, fch.f_gainset, fch.f_gain, err_clamp, state_dbg, g, clamped);
      end
      if (band_q[i] > 16) clamped = 1'b1;
    end
    gain_change = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fch.f_gainset !== 1'b1 || fch.f_gainwe !== 1'b0 || fch.f_gain !== 12'h0 ||
        err_clamp !== clamped || state_dbg !== SET) begin
      n_fail++;
      $display("FAIL set_cycle: set=%b we=%b gain=%h clamp=%b state=%0d want set=1 we=0 gain=0 clamp=%b state=3",
               fch.f_gainset, fch.f_gainwe, fch.f_gain, err_clamp, state_dbg, clamped);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || fch.f_gainset !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL idle_return: busy=%b in_ready=%b set=%b state=%0d want busy=0 in_ready=1 set=0 state=0",
               busy, in_ready, fch.f_gainset, state_dbg);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    fch.f_out_valid = 1'b0;
    fch.f_dout = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (state_dbg !== IDLE || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        dout !== '0 || err_clamp !== 1'b0 || err_flow !== 1'b0 || fch.f_gainwe !== 1'b0 ||
        fch.f_gainset !== 1'b0 || fch.f_gain !== 12'h0 || fch.f_in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d rdy=%b busy=%b ov=%b dout=%h ec=%b ef=%b we=%b set=%b gain=%h fiv=%b want idle/ready only",
               state_dbg, in_ready, busy, out_valid, dout, err_clamp, err_flow,
               fch.f_gainwe, fch.f_gainset, fch.f_gain, fch.f_in_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    din_valid = 1'b1;
    din = 16'h1234;
    @(negedge clk);
    din_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || dout !== 19'h01234) begin
      n_fail++;
      $display("FAIL bypass_after_reset: ov=%b dout=%h want ov=1 dout=01234", out_valid, dout);
    end
  endtask

  task automatic test_unity();
    for (int i = 0; i < N; i++) band_q[i] = 8;
    issue_change();
    check_load(-1);
  endtask

  task automatic test_band_map();
    rand_legal();
    band_q[3] = 0;
    band_q[7] = 16;
    issue_change();
    check_load(-1);
  endtask

  task automatic test_clamp();
    rand_legal();
    band_q[2] = 200;
    issue_change();
    check_load(-1);
    rand_legal();
    issue_change();
    n_cmp++;
    if (err_clamp !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_sticky: err_clamp=%b want 1", err_clamp);
    end
    check_load(-1);
  endtask

  task automatic test_back_to_back();
    rand_legal();
    issue_change();
    check_load(3);
    rand_legal();
    pack_bands();
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== DRAIN) begin
      n_fail++;
      $display("FAIL queued_drain: state=%0d want 1", state_dbg);
    end
    check_load(-1);
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== IDLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL requests_collapse: state=%0d busy=%b want state=0 busy=0", state_dbg, busy);
    end
  endtask

  task automatic test_random_loads();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++)
        band_q[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 255) : $urandom_range(0, 16);
      issue_change();
      check_load(-1);
    end
  endtask

  task automatic test_reset_mid();
    rand_legal();
    issue_change();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (state_dbg !== IDLE || fch.f_gainwe !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_load: state=%0d we=%b busy=%b rdy=%b want state=0 we=0 busy=0 rdy=1",
               state_dbg, fch.f_gainwe, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_drain();
    eq_switch = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'b1;
      din = DIN_W'($urandom);
      #1;
      n_cmp++;
      if (fch.f_in_valid !== 1'b1 || fch.f_din !== din) begin
        n_fail++;
        $display("FAIL eq_push%0d: fiv=%b fdin=%h want fiv=1 fdin=%h", i, fch.f_in_valid, fch.f_din, din);
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    rand_legal();
    issue_change();
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1;
      #1;
      n_cmp++;
      if (fch.f_in_valid !== 1'b0 || in_ready !== 1'b0 || state_dbg !== DRAIN || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_hold%0d: fiv=%b rdy=%b state=%0d ov=%b want fiv=0 rdy=0 state=1 ov=0",
                 i, fch.f_in_valid, in_ready, state_dbg, out_valid);
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fch.f_out_valid = 1'b1;
      fch.f_dout = DOUT_W'($urandom);
      exp_q.push_back(fch.f_dout);
      @(negedge clk);
      fch.f_out_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || dout !== exp_q[0] || state_dbg !== DRAIN) begin
        n_fail++;
        $display("FAIL drain_release%0d: ov=%b dout=%h state=%0d want ov=1 dout=%h state=1",
                 i, out_valid, dout, state_dbg, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    check_load(-1);
  endtask

  task automatic test_mode_switch();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) eq_switch = 1'b0;
      din_valid = 1'b1;
      din = DIN_W'($urandom);
      #1;
      n_cmp++;
      if (fch.f_in_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL eq_held_push%0d: fiv=%b want 1", i, fch.f_in_valid);
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fch.f_out_valid = 1'b1;
      fch.f_dout = DOUT_W'($urandom);
      exp_q.push_back(fch.f_dout);
      @(negedge clk);
      fch.f_out_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || dout !== exp_q[0]) begin
        n_fail++;
        $display("FAIL eq_forward%0d: ov=%b dout=%h want ov=1 dout=%h", i, out_valid, dout, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL switch_gap: ov=%b want 0", out_valid);
    end
    din_valid = 1'b1;
    din = 16'hFFFF;
    #1;
    n_cmp++;
    if (fch.f_in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_no_filter: fiv=%b want 0", fch.f_in_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || dout !== 19'h7FFFF) begin
      n_fail++;
      $display("FAIL bypass_sext: ov=%b dout=%h want ov=1 dout=7ffff", out_valid, dout);
    end
    for (int i = 0; i < 6; i++) begin
      logic v;
      logic [DOUT_W-1:0] e;
      v = 1'($urandom_range(0, 1));
      din_valid = v;
      din = DIN_W'($urandom);
      e = {{(DOUT_W - DIN_W){din[DIN_W-1]}}, din};
      @(negedge clk);
      n_cmp++;
      if (out_valid !== v || (v && dout !== e)) begin
        n_fail++;
        $display("FAIL bypass_rand%0d: ov=%b dout=%h want ov=%b dout=%h", i, out_valid, dout, v, e);
      end
    end
    din_valid = 1'b0;
    n_cmp++;
    if (err_flow !== 1'b0) begin
      n_fail++;
      $display("FAIL flow_clean: err_flow=%b want 0", err_flow);
    end
    fch.f_out_valid = 1'b1;
    fch.f_dout = 19'h12345;
    @(negedge clk);
    fch.f_out_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err_flow !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_output: err_flow=%b ov=%b want err_flow=1 ov=0", err_flow, out_valid);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_unity();
    test_band_map();
    test_clamp();
    test_back_to_back();
    test_random_loads();
    test_reset_mid();
    test_drain();
    test_mode_switch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule
